axis_phase_accumulator: RTL and testbench

AXIS_PHASE_ACCUMULATOR -- requirements
Module: axis_phase_accumulator

---
 rtl/sdr_axis_pkg.sv | 13 +
 rtl/nco_phase_acc.sv | 45 ++++
 rtl/axis_phase_accumulator.sv | 78 +++++++
 tb/tb_axis_phase_accumulator.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sdr_axis_pkg.sv
// Shared types and default widths for the AXI-Stream SDR blocks.
// Pure declarations: no logic, no latency, no flow control.
package sdr_axis_pkg;

  localparam int PHASE_WIDTH_DEF = 32;
  localparam int OUT_WIDTH_DEF   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/nco_phase_acc.sv
// Phase accumulator core: holds pinc and acc, adds modulo 2^PHASE_WIDTH when advanced.
// One-cycle latency from adv_en to phase_o; stalls simply by holding adv_en low.
module nco_phase_acc
  import sdr_axis_pkg::*;
#(
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   load_en,
  input  logic [PHASE_WIDTH-1:0] pinc_in,
  input  logic                   adv_en,
  output logic [OUT_WIDTH-1:0]   phase_o
);

  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [PHASE_WIDTH-1:0] pinc_q, pinc_d;

  // The advance always uses the increment held before this edge, so a
  // simultaneous load only takes effect from the following advance.
  always_comb begin
    acc_d  = acc_q;
    pinc_d = pinc_q;
    if (adv_en) begin
      acc_d = acc_q + pinc_q;
    end
    if (load_en) begin
      pinc_d = pinc_in;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q  <= '0;
      pinc_q <= '0;
    end else begin
      acc_q  <= acc_d;
      pinc_q <= pinc_d;
    end
  end

  assign phase_o = acc_q[PHASE_WIDTH-1 -: OUT_WIDTH];

endmodule

// File: rtl/axis_phase_accumulator.sv
// AXI-Stream NCO phase source: idle until the first pinc beat, then streams acc MSBs.
// One-cycle latency per handshake; output holds while m_axis_phase_tready is low.
module axis_phase_accumulator
  import sdr_axis_pkg::*;
#(
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [PHASE_WIDTH-1:0] s_axis_config_tdata,
  input  logic                   s_axis_config_tvalid,
  output logic                   s_axis_config_tready,
  output logic [OUT_WIDTH-1:0]   m_axis_phase_tdata,
  output logic                   m_axis_phase_tvalid,
  input  logic                   m_axis_phase_tready
);

  state_t state_q, state_d;
  logic   cfg_rdy_q, cfg_rdy_d;
  logic   phase_vld_q, phase_vld_d;
  logic   cfg_fire;
  logic   phase_fire;

  assign cfg_fire   = s_axis_config_tvalid & cfg_rdy_q;
  assign phase_fire = phase_vld_q & m_axis_phase_tready;

  // cfg_rdy_q rises on the first edge after reset release, so nothing can
  // leave IDLE until deassertion has been seen synchronously.
  always_comb begin
    state_d     = state_q;
    phase_vld_d = phase_vld_q;
    cfg_rdy_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if (cfg_fire) begin
          state_d     = RUN;
          phase_vld_d = 1'b1;
        end
      end
      RUN: begin
        phase_vld_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        phase_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      cfg_rdy_q   <= 1'b0;
      phase_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_rdy_q   <= cfg_rdy_d;
      phase_vld_q <= phase_vld_d;
    end
  end

  nco_phase_acc #(
    .PHASE_WIDTH (PHASE_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH)
  ) u_nco_phase_acc (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load_en (cfg_fire),
    .pinc_in (s_axis_config_tdata),
    .adv_en  (phase_fire),
    .phase_o (m_axis_phase_tdata)
  );

  assign s_axis_config_tready = cfg_rdy_q;
  assign m_axis_phase_tvalid  = phase_vld_q;

endmodule

// File: tb/tb_axis_phase_accumulator.sv
// Bench for axis_phase_accumulator: directed scenarios plus a randomized run,
// with a handshake-level scoreboard on the output stream.
module tb_axis_phase_accumulator;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] cfg_dat;
  logic        cfg_vld;
  logic        cfg_rdy;
  logic [15:0] ph_dat;
  logic        ph_vld;
  logic        ph_rdy;

  int nvec = 0;
  int nerr = 0;

  logic [15:0] exp_q[$];

  // Independent behavioural reference
  logic        mdl_rdy;
  logic        mdl_vld;
  logic [31:0] mdl_acc;
  logic [31:0] mdl_pinc;

  always #5 aclk = ~aclk;

  axis_phase_accumulator #(
    .PHASE_WIDTH (32),
    .OUT_WIDTH   (16)
  ) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_config_tdata  (cfg_dat),
    .s_axis_config_tvalid (cfg_vld),
    .s_axis_config_tready (cfg_rdy),
    .m_axis_phase_tdata   (ph_dat),
    .m_axis_phase_tvalid  (ph_vld),
    .m_axis_phase_tready  (ph_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, predict, advance, check control outputs after the edge.
  task automatic step(input logic cv, input logic [31:0] cd, input logic rdy);
    logic [31:0] acc_n;
    logic [31:0] pinc_n;
    logic        vld_n;
    cfg_vld = cv;
    cfg_dat = cd;
    ph_rdy  = rdy;
    acc_n   = mdl_acc;
    pinc_n  = mdl_pinc;
    vld_n   = mdl_vld;
    if (mdl_vld && rdy) begin
      exp_q.push_back(mdl_acc[31:16]);
      acc_n = mdl_acc + mdl_pinc;
    end
    if (cv && mdl_rdy) begin
      pinc_n = cd;
      vld_n  = 1'b1;
    end
    @(posedge aclk);
    #1;
    mdl_acc  = acc_n;
    mdl_pinc = pinc_n;
    mdl_vld  = vld_n;
    mdl_rdy  = 1'b1;
    chk("s_tready", {31'd0, cfg_rdy}, {31'd0, mdl_rdy});
    chk("m_tvalid", {31'd0, ph_vld}, {31'd0, mdl_vld});
  endtask

  task automatic do_reset(input int cycles);
    aresetn = 1'b0;
    cfg_vld = 1'b0;
    mdl_rdy  = 1'b0;
    mdl_vld  = 1'b0;
    mdl_acc  = '0;
    mdl_pinc = '0;
    #1;
    chk("rst_tready", {31'd0, cfg_rdy}, 32'd0);
    chk("rst_tvalid", {31'd0, ph_vld}, 32'd0);
    chk("rst_tdata", {16'd0, ph_dat}, 32'd0);
    repeat (cycles) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    step(1'b0, 32'd0, 1'b1);
  endtask

  // Scoreboard: every DUT handshake must match the next predicted phase.
  always @(negedge aclk) begin
    if (aresetn && ph_vld && ph_rdy) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_hs", 32'd1, 32'd0);
      end else begin
        chk("sb_tdata", {16'd0, ph_dat}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    cfg_vld = 1'b0;
    cfg_dat = '0;
    ph_rdy  = 1'b1;
    aresetn = 1'b0;
    #2;
    do_reset(2);

    // Idle: no config beat for 50 cycles
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 32'd0, 1'b1);
    end
    chk("idle_tdata", {16'd0, ph_dat}, 32'd0);

    // Startup
    step(1'b1, 32'h0100_0000, 1'b1);
    chk("start0", {16'd0, ph_dat}, 32'h0000);
    step(1'b0, 32'd0, 1'b1);
    chk("start1", {16'd0, ph_dat}, 32'h0100);
    step(1'b0, 32'd0, 1'b1);
    chk("start2", {16'd0, ph_dat}, 32'h0200);
    step(1'b0, 32'd0, 1'b1);
    chk("start3", {16'd0, ph_dat}, 32'h0300);

    // Wrap
    do_reset(1);
    step(1'b1, 32'h8000_0000, 1'b1);
    chk("wrap0", {16'd0, ph_dat}, 32'h0000);
    step(1'b0, 32'd0, 1'b1);
    chk("wrap1", {16'd0, ph_dat}, 32'h8000);
    step(1'b0, 32'd0, 1'b1);
    chk("wrap2", {16'd0, ph_dat}, 32'h0000);
    step(1'b0, 32'd0, 1'b1);
    chk("wrap3", {16'd0, ph_dat}, 32'h8000);

    // Backpressure
    do_reset(1);
    step(1'b1, 32'h0001_0000, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    chk("bp_pre", {16'd0, ph_dat}, 32'h0002);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'd0, 1'b0);
      chk("bp_hold", {16'd0, ph_dat}, 32'h0002);
    end
    step(1'b0, 32'd0, 1'b1);
    chk("bp_post", {16'd0, ph_dat}, 32'h0003);
    step(1'b0, 32'd0, 1'b1);
    chk("bp_next", {16'd0, ph_dat}, 32'h0004);

    // Config accepted together with an output handshake
    step(1'b1, 32'h0010_0000, 1'b1);
    chk("simul_old", {16'd0, ph_dat}, 32'h0005);
    step(1'b0, 32'd0, 1'b1);
    chk("simul_new", {16'd0, ph_dat}, 32'h0015);

    // pinc = 0 holds phase with tvalid high
    step(1'b1, 32'h0000_0000, 1'b1);
    chk("zero_a", {16'd0, ph_dat}, 32'h0025);
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    chk("zero_hold", {16'd0, ph_dat}, 32'h0025);

    // Reset mid-RUN
    step(1'b1, 32'h0003_0000, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'd0, 1'b1);
    end
    chk("rerun_idle", {16'd0, ph_dat}, 32'h0000);
    step(1'b1, 32'h0100_0000, 1'b1);
    chk("rerun0", {16'd0, ph_dat}, 32'h0000);
    step(1'b0, 32'd0, 1'b1);
    chk("rerun1", {16'd0, ph_dat}, 32'h0100);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 7) == 0), $urandom, $urandom_range(0, 1) == 1);
    end
    step(1'b0, 32'd0, 1'b0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
